// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer:
// opcodes, FSM state encodings, PC source selects and default ALU codes.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // shamt and funct together must match exactly for an add
  localparam logic [10:0] FUNCT_ADD = 11'h020;

  localparam logic [4:0] ALUOP_ADD = 5'h01;
  localparam logic [4:0] ALUOP_GTZ = 5'h07;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_JUMP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    OPT_R   = 2'd0,
    OPT_I   = 2'd1,
    OPT_J   = 2'd2,
    OPT_ILL = 2'd3
  } optype_t;

  typedef struct packed {
    logic add;
    logic addi;
    logic lw;
    logic sw;
    logic bgtz;
    logic j;
    logic illegal;
  } insn_class_t;

  function automatic logic [1:0] class_optype(insn_class_t c);
    if (c.add)     return OPT_R;
    if (c.j)       return OPT_J;
    if (c.illegal) return OPT_ILL;
    return OPT_I;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the instruction register to a
// one-hot class {add, addi, lw, sw, bgtz, j, illegal}.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  instruction,
  output insn_class_t  insn_class
);

  // register fields are the datapath's business, not the sequencer's
  logic unused_fields;
  assign unused_fields = ^instruction[25:11];

  always_comb begin
    insn_class = '0;
    case (instruction[31:26])
      OP_RTYPE: begin
        if (instruction[10:0] == FUNCT_ADD) insn_class.add = 1'b1;
        else                                insn_class.illegal = 1'b1;
      end
      OP_ADDI: insn_class.addi    = 1'b1;
      OP_LW:   insn_class.lw      = 1'b1;
      OP_SW:   insn_class.sw      = 1'b1;
      OP_BGTZ: insn_class.bgtz    = 1'b1;
      OP_J:    insn_class.j       = 1'b1;
      default: insn_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for add/addi/lw/sw/j/bgtz with a shared memory port
// and bus timeout. Define MC_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [4:0] ADD_ALUOP      = ALUOP_ADD,
  parameter logic [4:0] GTZ_ALUOP      = ALUOP_GTZ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        alu_gtz,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  optype,
  output logic [4:0]  aluop,
  output logic        alu_srcb,
  output logic        regwe,
  output logic        reg_AOM,
  output logic        bus_err,
  output logic        illegal,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic        halted,
`endif
  output logic [2:0]  state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            cur_state, nxt_state;
  insn_class_t       cls;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              retry_gap;
  logic              wait_cycle;
  logic              timeout_hit;
  logic              halted_q;

  mc_decode u_decode (
    .instruction (instruction),
    .insn_class  (cls)
  );

  // The cycle after a timeout leaves FETCH idle so the request visibly drops
  assign wait_cycle  = ((cur_state == S_FETCH && !retry_gap) || cur_state == S_MEM) && !mem_ready;
  assign timeout_hit = wait_cycle && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign state       = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      tmo_cnt   <= '0;
      retry_gap <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      retry_gap <= timeout_hit;
      if (wait_cycle && !timeout_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                            tmo_cnt <= '0;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  halted_q <= 1'b0;
    else if (cur_state == S_DECODE && cls.illegal) halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted_q = 1'b0;
`endif

  always_comb begin
    nxt_state = cur_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    optype    = OPT_R;
    aluop     = 5'h00;
    alu_srcb  = 1'b0;
    regwe     = 1'b0;
    reg_AOM   = 1'b0;
    bus_err   = 1'b0;
    illegal   = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (!halted_q) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        if (!retry_gap) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            nxt_state = S_DECODE;
          end else if (timeout_hit) begin
            bus_err = 1'b1;
          end
        end
      end
      S_DECODE: begin
        optype = class_optype(cls);
        if (cls.add || cls.addi || cls.lw || cls.sw) nxt_state = S_EXEC;
        else if (cls.bgtz)                           nxt_state = S_BRANCH;
        else if (cls.j)                              nxt_state = S_JUMP;
        else begin
          illegal = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
          nxt_state = S_IDLE;
`else
          nxt_state = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        aluop     = ADD_ALUOP;
        alu_srcb  = !cls.add;
        nxt_state = (cls.lw || cls.sw) ? S_MEM : S_WB;
      end
      // A timed-out load/store is dropped without writeback
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = cls.sw;
        if (mem_ready) begin
          nxt_state = cls.sw ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          bus_err   = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_WB: begin
        regwe     = 1'b1;
        reg_AOM   = !cls.lw;
        nxt_state = S_FETCH;
      end
      S_BRANCH: begin
        aluop     = GTZ_ALUOP;
        pc_src    = PC_BRANCH;
        pc_we     = alu_gtz;
        nxt_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = PC_JUMP;
        pc_we     = 1'b1;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule
